// File: rtl/tx_frame_sequencer.sv
// Serial transmit framer: preamble, 8 data bits MSB first, even parity, then an idle gap.
// Carries its own bit-period divider; one frame per byte accepted on the valid/ready side.
module tx_frame_sequencer #(
   parameter int unsigned BIT_CYCLES = 12500,
   parameter int unsigned PRE_LEN    = 8,
   parameter logic [15:0] PREAMBLE   = 16'h00AA,
   parameter int unsigned GAP_BITS   = 2
) (
   input  logic       clk_in,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       abort,
   output logic       tx_bit,
   output logic       tx_active,
   output logic       bit_tick,
   output logic       frame_done
);

   localparam int unsigned DW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam int unsigned GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(BIT_CYCLES - 1);
   localparam logic [3:0]    PRE_LAST = 4'(PRE_LEN - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_BITS - 1);
   // Preamble left-justified so its first bit to send always sits at bit 15.
   localparam logic [15:0]   PRE_ALIGNED = PREAMBLE << (16 - PRE_LEN);

   typedef enum logic [2:0] {S_IDLE, S_PRE, S_DATA, S_PAR, S_GAP} state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] div_q, div_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [15:0]   pre_sr_q, pre_sr_d;
   logic [7:0]    data_sr_q, data_sr_d;
   logic          parity_q, parity_d;
   logic          tx_bit_q, tx_bit_d;
   logic          tx_active_q, tx_active_d;
   logic          bit_tick_q, bit_tick_d;
   logic          frame_done_q, frame_done_d;
   logic          accept, tick;

   assign tx_ready   = (state_q == S_IDLE) & ~abort;
   assign accept     = tx_valid & tx_ready;
   assign tick       = (state_q != S_IDLE) && (div_q == DIV_LAST);
   assign tx_bit     = tx_bit_q;
   assign tx_active  = tx_active_q;
   assign bit_tick   = bit_tick_q;
   assign frame_done = frame_done_q;

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         div_q        <= '0;
         cnt_q        <= '0;
         gap_q        <= '0;
         pre_sr_q     <= '0;
         data_sr_q    <= '0;
         parity_q     <= 1'b0;
         tx_bit_q     <= 1'b0;
         tx_active_q  <= 1'b0;
         bit_tick_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         div_q        <= div_d;
         cnt_q        <= cnt_d;
         gap_q        <= gap_d;
         pre_sr_q     <= pre_sr_d;
         data_sr_q    <= data_sr_d;
         parity_q     <= parity_d;
         tx_bit_q     <= tx_bit_d;
         tx_active_q  <= tx_active_d;
         bit_tick_q   <= bit_tick_d;
         frame_done_q <= frame_done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (state_q == S_IDLE) begin
         if (accept) state_d = S_PRE;
      end else if (abort) begin
         state_d = S_IDLE;
      end else if (tick) begin
         case (state_q)
            S_PRE:   if (cnt_q == PRE_LAST) state_d = S_DATA;
            S_DATA:  if (cnt_q == 4'd7) state_d = S_PAR;
            S_PAR:   state_d = S_GAP;
            S_GAP:   if (gap_q == GAP_LAST) state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      div_d        = div_q;
      cnt_d        = cnt_q;
      gap_d        = gap_q;
      pre_sr_d     = pre_sr_q;
      data_sr_d    = data_sr_q;
      parity_d     = parity_q;
      tx_bit_d     = tx_bit_q;
      tx_active_d  = tx_active_q;
      frame_done_d = 1'b0;
      if (state_q == S_IDLE) begin
         div_d = '0;
         if (accept) begin
            data_sr_d   = tx_data;
            parity_d    = ^tx_data;
            pre_sr_d    = PRE_ALIGNED << 1;
            tx_bit_d    = PRE_ALIGNED[15];
            tx_active_d = 1'b1;
            cnt_d       = '0;
            gap_d       = '0;
         end
      end else if (abort) begin
         div_d       = '0;
         cnt_d       = '0;
         gap_d       = '0;
         tx_bit_d    = 1'b0;
         tx_active_d = 1'b0;
      end else if (tick) begin
         div_d = '0;
         case (state_q)
            S_PRE: begin
               if (cnt_q == PRE_LAST) begin
                  cnt_d     = '0;
                  tx_bit_d  = data_sr_q[7];
                  data_sr_d = {data_sr_q[6:0], 1'b0};
               end else begin
                  cnt_d    = cnt_q + 4'd1;
                  tx_bit_d = pre_sr_q[15];
                  pre_sr_d = {pre_sr_q[14:0], 1'b0};
               end
            end
            S_DATA: begin
               if (cnt_q == 4'd7) begin
                  cnt_d    = '0;
                  tx_bit_d = parity_q;
               end else begin
                  cnt_d     = cnt_q + 4'd1;
                  tx_bit_d  = data_sr_q[7];
                  data_sr_d = {data_sr_q[6:0], 1'b0};
               end
            end
            S_PAR: begin
               tx_bit_d = 1'b0;
               gap_d    = '0;
            end
            S_GAP: begin
               if (gap_q == GAP_LAST) begin
                  tx_active_d  = 1'b0;
                  frame_done_d = 1'b1;
               end else begin
                  gap_d = gap_q + GW'(1);
               end
            end
            default: tx_bit_d = 1'b0;
         endcase
      end else begin
         div_d = div_q + DW'(1);
      end
   end

   // bit_tick is registered, so it is decoded from the divider value about to be loaded.
   always_comb begin
      bit_tick_d = (state_d != S_IDLE) && (div_d == DIV_LAST);
   end

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Directed bench for tx_frame_sequencer with a 4-cycle bit period and 19-bit frames.
module tb_tx_frame_sequencer;

   logic       clk_in = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       abort = 1'b0;
   logic       tx_ready, tx_bit, tx_active, bit_tick, frame_done;

   int n_vec  = 0;
   int n_miss = 0;

   tx_frame_sequencer #(
      .BIT_CYCLES(4),
      .PRE_LEN   (8),
      .PREAMBLE  (16'h00AA),
      .GAP_BITS  (2)
   ) dut (
      .clk_in    (clk_in),
      .rst       (rst),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .abort     (abort),
      .tx_bit    (tx_bit),
      .tx_active (tx_active),
      .bit_tick  (bit_tick),
      .frame_done(frame_done)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Present a byte, wait (bounded) for ready, then let it be accepted at the next edge.
   task automatic start(input logic [7:0] d);
      int w = 0;
      @(negedge clk_in);
      tx_data  = d;
      tx_valid = 1'b1;
      while (!tx_ready && w < 200) begin
         @(negedge clk_in);
         w++;
      end
      chk("start.ready", 32'(tx_ready), 32'd1);
      @(posedge clk_in);
      #1 tx_valid = 1'b0;
   endtask

   // Called just after the accept edge N; checks cycles N..N+76.
   task automatic watch(input string tag, input logic [18:0] exp);
      int ticks = 0;
      for (int c = 0; c < 76; c++) begin
         @(negedge clk_in);
         chk({tag, ".bit"},    32'(tx_bit),     32'(exp[18 - c / 4]));
         chk({tag, ".tick"},   32'(bit_tick),   32'((c % 4) == 3));
         chk({tag, ".active"}, 32'(tx_active),  32'd1);
         chk({tag, ".done"},   32'(frame_done), 32'd0);
         chk({tag, ".ready"},  32'(tx_ready),   32'd0);
         if (bit_tick) ticks++;
      end
      @(negedge clk_in);
      chk({tag, ".end_done"},   32'(frame_done), 32'd1);
      chk({tag, ".end_active"}, 32'(tx_active),  32'd0);
      chk({tag, ".end_bit"},    32'(tx_bit),     32'd0);
      chk({tag, ".end_tick"},   32'(bit_tick),   32'd0);
      chk({tag, ".end_ready"},  32'(tx_ready),   32'd1);
      chk({tag, ".ticks"},      32'(ticks),      32'd19);
      $display("frame %s expected bits %b checked", tag, exp);
   endtask

   initial begin
      int dones;
      int actives;

      // Reset state
      repeat (3) @(negedge clk_in);
      chk("rst.bit",    32'(tx_bit),     32'd0);
      chk("rst.active", 32'(tx_active),  32'd0);
      chk("rst.tick",   32'(bit_tick),   32'd0);
      chk("rst.done",   32'(frame_done), 32'd0);
      chk("rst.ready",  32'(tx_ready),   32'd1);
      rst = 1'b0;

      // Basic frame 3C
      start(8'h3C);
      watch("s1_3C", 19'b1010101000111100000);

      // Parity 1 and 0
      start(8'h07);
      watch("s2_07", 19'b1010101000000111100);
      start(8'h00);
      watch("s2_00", 19'b1010101000000000000);

      // Back-to-back with valid held high; data changes after accept
      @(negedge clk_in);
      tx_data  = 8'h01;
      tx_valid = 1'b1;
      @(posedge clk_in);
      fork
         watch("s3_01", 19'b1010101000000001100);
         begin
            @(negedge clk_in);
            tx_data = 8'h02;
         end
      join
      @(posedge clk_in);
      #1 tx_valid = 1'b0;
      watch("s3_02", 19'b1010101000000010100);

      // Mid-frame valid with FF is ignored
      start(8'h3C);
      fork
         watch("s4_3C", 19'b1010101000111100000);
         begin
            repeat (30) @(negedge clk_in);
            #1 tx_data = 8'hFF;
            tx_valid = 1'b1;
            repeat (4) @(negedge clk_in);
            #1 tx_valid = 1'b0;
            tx_data = 8'h00;
         end
      join
      @(negedge clk_in);
      chk("s4.no_accept", 32'(tx_active), 32'd0);

      // Abort during data phase, just before a bit_tick would rise
      start(8'h3C);
      repeat (43) @(negedge clk_in);
      chk("s5.pre_bit",    32'(tx_bit),    32'd1);
      chk("s5.pre_active", 32'(tx_active), 32'd1);
      abort = 1'b1;
      @(posedge clk_in);
      #1 abort = 1'b0;
      @(negedge clk_in);
      chk("s5.bit",    32'(tx_bit),    32'd0);
      chk("s5.active", 32'(tx_active), 32'd0);
      chk("s5.tick",   32'(bit_tick),  32'd0);
      chk("s5.ready",  32'(tx_ready),  32'd1);
      dones = 0;
      actives = 0;
      repeat (100) begin
         @(negedge clk_in);
         if (frame_done) dones++;
         if (tx_active) actives++;
      end
      chk("s5.no_done",   32'(dones),   32'd0);
      chk("s5.no_active", 32'(actives), 32'd0);
      $display("abort during data phase checked");

      // Abort in idle blocks accept for that cycle
      @(negedge clk_in);
      abort    = 1'b1;
      tx_valid = 1'b1;
      tx_data  = 8'h55;
      #1 chk("s5.idle_ready", 32'(tx_ready), 32'd0);
      @(posedge clk_in);
      #1 abort = 1'b0;
      tx_valid = 1'b0;
      @(negedge clk_in);
      chk("s5.idle_no_accept", 32'(tx_active), 32'd0);

      start(8'h3C);
      watch("s5_after", 19'b1010101000111100000);

      // Asynchronous reset mid-preamble while bit_tick is high
      start(8'h3C);
      repeat (4) @(negedge clk_in);
      chk("s6.pre_tick",   32'(bit_tick),  32'd1);
      chk("s6.pre_bit",    32'(tx_bit),    32'd1);
      chk("s6.pre_active", 32'(tx_active), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("s6.bit",    32'(tx_bit),     32'd0);
      chk("s6.active", 32'(tx_active),  32'd0);
      chk("s6.tick",   32'(bit_tick),   32'd0);
      chk("s6.done",   32'(frame_done), 32'd0);
      chk("s6.ready",  32'(tx_ready),   32'd1);
      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      rst = 1'b0;
      start(8'h3C);
      watch("s6_3C", 19'b1010101000111100000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
